// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
//   - estado_t : FSM state encodings (also shown on the debug output)
//   - classe_t : instruction class fed to the ALU-control decoder
//   - ALU operation codes, opcodes and datapath mux-select codes
package controle_pkg;

  localparam int unsigned ESTADO_BITS = 4;

  typedef enum logic [ESTADO_BITS-1:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StWbLoad   = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StWbR      = 4'd7,
    StBranch   = 4'd8,
    StJal      = 4'd9,
    StExecI    = 4'd10,
    StErro     = 4'd15
  } estado_t;

  typedef enum logic [1:0] {
    ClsOutro = 2'd0,
    ClsR     = 2'd1,
    ClsI     = 2'd2
  } classe_t;

  // ALU operations
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  // Opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Writeback select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_PC     = 2'd1;
  localparam logic [1:0] M2R_MDR    = 2'd2;

  // ALU A select
  localparam logic [1:0] ULA_A_PCBACK = 2'd0;
  localparam logic [1:0] ULA_A_REG    = 2'd1;
  localparam logic [1:0] ULA_A_PC     = 2'd2;

  // ALU B select
  localparam logic [1:0] ULA_B_REG   = 2'd0;
  localparam logic [1:0] ULA_B_QUATRO = 2'd1;
  localparam logic [1:0] ULA_B_IMM   = 2'd2;

endpackage

// File: rtl/controle_ula.sv
// ALU-control decoder (combinational).
//   iClasse     : instruction class (R-type, I-type, other)
//   iFunct3     : instruction funct3
//   iFunct7b5   : instruction funct7[5]
//   oALUControl : ALU operation for the execute state
//   oIlegal     : funct3/funct7 combination not supported for the class
module controle_ula
  import controle_pkg::*;
(
  input  classe_t    iClasse,
  input  logic [2:0] iFunct3,
  input  logic       iFunct7b5,
  output logic [3:0] oALUControl,
  output logic       oIlegal
);

  always_comb begin
    oALUControl = ALU_ADD;
    oIlegal     = 1'b0;
    case (iClasse)
      ClsR: begin
        case (iFunct3)
          3'b000:  oALUControl = iFunct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  oALUControl = ALU_AND;
          3'b110:  oALUControl = ALU_OR;
          3'b010:  oALUControl = ALU_SLT;
          default: oIlegal = 1'b1;
        endcase
        // Only add/sub use the alternate funct7 encoding.
        if (iFunct7b5 && (iFunct3 != 3'b000)) begin
          oIlegal = 1'b1;
        end
      end
      ClsI: begin
        // funct7 bits belong to the immediate here.
        case (iFunct3)
          3'b000:  oALUControl = ALU_ADD;
          3'b111:  oALUControl = ALU_AND;
          3'b110:  oALUControl = ALU_OR;
          3'b010:  oALUControl = ALU_SLT;
          default: oIlegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle RV32I processor.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
//   iCLK, iRST  : clock, synchronous active-high reset
//   iInst       : instruction register (stable from DECODE on)
//   iZero       : ALU zero flag (branch decision)
//   oEscrevePC, oEscreveIR, oLeMem, oEscreveMem, oEscreveReg : enables
//   oIouD, oMem2Reg, oOrigAULA, oOrigBULA, oOrigPC : datapath mux selects
//   oALUControl : ALU operation
//   oEstado     : current state (debug), oErro : high while in ERRO
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned ESTADO_W  = 4,
  parameter bit          ERRO_HALT = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [31:0]         iInst,
  input  logic                iZero,
  output logic                oEscrevePC,
  output logic                oEscreveIR,
  output logic                oIouD,
  output logic                oLeMem,
  output logic                oEscreveMem,
  output logic                oEscreveReg,
  output logic [1:0]          oMem2Reg,
  output logic [1:0]          oOrigAULA,
  output logic [1:0]          oOrigBULA,
  output logic                oOrigPC,
  output logic [3:0]          oALUControl,
  output logic [ESTADO_W-1:0] oEstado,
  output logic                oErro
);

  estado_t    estado_q, estado_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  classe_t    classe;
  logic [3:0] ula_op;
  logic       ula_ilegal;
  logic       ilegal;
  logic       unused_inst;

  assign opcode      = iInst[6:0];
  assign funct3      = iInst[14:12];
  assign unused_inst = ^{iInst[31], iInst[29:15], iInst[11:7]};

  assign classe = (opcode == OPC_RTYPE) ? ClsR :
                  (opcode == OPC_OPIMM) ? ClsI : ClsOutro;

  // The decoder looks at the instruction directly, so its illegal flag is valid in DECODE
  // and its ALU code is valid in EXEC_R/EXEC_I.
  controle_ula u_ula (
    .iClasse     (classe),
    .iFunct3     (funct3),
    .iFunct7b5   (iInst[30]),
    .oALUControl (ula_op),
    .oIlegal     (ula_ilegal)
  );

  always_comb begin
    case (opcode)
      OPC_LOAD, OPC_STORE:   ilegal = (funct3 != 3'b010);
      OPC_RTYPE, OPC_OPIMM:  ilegal = ula_ilegal;
      OPC_BRANCH:            ilegal = (funct3 != 3'b000);
      OPC_JAL:               ilegal = 1'b0;
      default:               ilegal = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      estado_q <= StFetch;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = StFetch;
    case (estado_q)
      StFetch: estado_d = StDecode;
      StDecode: begin
        if (ilegal) begin
          estado_d = ERRO_HALT ? StErro : StFetch;
        end else begin
          case (opcode)
            OPC_LOAD, OPC_STORE: estado_d = StMemAddr;
            OPC_RTYPE:           estado_d = StExecR;
            OPC_OPIMM:           estado_d = StExecI;
            OPC_BRANCH:          estado_d = StBranch;
            default:             estado_d = StJal;
          endcase
        end
      end
      StMemAddr: estado_d = (opcode == OPC_LOAD) ? StMemRead : StMemWrite;
      StMemRead: estado_d = StWbLoad;
      StExecR,
      StExecI:   estado_d = StWbR;
      StErro:    estado_d = StErro;
      default:   estado_d = StFetch;
    endcase
  end

  always_comb begin
    oEscrevePC  = 1'b0;
    oEscreveIR  = 1'b0;
    oIouD       = 1'b0;
    oLeMem      = 1'b0;
    oEscreveMem = 1'b0;
    oEscreveReg = 1'b0;
    oMem2Reg    = M2R_ALUOUT;
    oOrigAULA   = ULA_A_PCBACK;
    oOrigBULA   = ULA_B_REG;
    oOrigPC     = 1'b0;
    oALUControl = ALU_ADD;
    oErro       = 1'b0;
    case (estado_q)
      StFetch: begin
        oLeMem     = 1'b1;
        oEscreveIR = 1'b1;
        oOrigAULA  = ULA_A_PC;
        oOrigBULA  = ULA_B_QUATRO;
        oEscrevePC = 1'b1;
      end
      StDecode: begin
        // ALUOut <= PCBack + imm, the branch/jump target.
        oOrigAULA = ULA_A_PCBACK;
        oOrigBULA = ULA_B_IMM;
      end
      StMemAddr: begin
        oOrigAULA = ULA_A_REG;
        oOrigBULA = ULA_B_IMM;
      end
      StMemRead: begin
        oIouD  = 1'b1;
        oLeMem = 1'b1;
      end
      StWbLoad: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_MDR;
      end
      StMemWrite: begin
        oIouD       = 1'b1;
        oEscreveMem = 1'b1;
      end
      StExecR: begin
        oOrigAULA   = ULA_A_REG;
        oOrigBULA   = ULA_B_REG;
        oALUControl = ula_op;
      end
      StExecI: begin
        oOrigAULA   = ULA_A_REG;
        oOrigBULA   = ULA_B_IMM;
        oALUControl = ula_op;
      end
      StWbR: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_ALUOUT;
      end
      StBranch: begin
        oOrigAULA   = ULA_A_REG;
        oOrigBULA   = ULA_B_REG;
        oALUControl = ALU_SUB;
        oOrigPC     = 1'b1;
        oEscrevePC  = iZero;
      end
      StJal: begin
        // rd gets the still-old PC (already PC+4) as PC takes ALUOut on this edge.
        oOrigPC     = 1'b1;
        oEscrevePC  = 1'b1;
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_PC;
      end
      StErro: oErro = 1'b1;
      default: ;
    endcase

    if (iRST) begin
      oEscrevePC  = 1'b0;
      oEscreveIR  = 1'b0;
      oLeMem      = 1'b0;
      oEscreveMem = 1'b0;
      oEscreveReg = 1'b0;
      oErro       = 1'b0;
    end
  end

  assign oEstado = iRST ? '0 : ESTADO_W'(estado_q);

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Main control FSM for the multicycle RV32I processor. It sequences the shared datapath (PC, IR, register file, single memory, ALU, ALUOut/MDR registers and immediate generator) through fetch/decode/execute/memory/writeback.
- Supported instructions: lw, sw, beq, jal, R-type add/sub/and/or/slt, and I-type addi/andi/ori/slti.
- Illegal encodings trap to an error state.

Parameters:
ESTADO_W, 4, width of the state register and of oEstado.
ERRO_HALT, 1, 1: an illegal instruction parks in ERRO until reset; 0: an illegal instruction returns to FETCH as a NOP.

Ports:
iCLK  in  1  system clock, rising edge.
iRST  in  1  synchronous reset, active-high.
iInst  in  32  instruction register output, stable from DECODE onward.
iZero  in  1  ALU zero flag.
oEscrevePC  out  1  PC write enable.
oEscreveIR  out  1  IR write enable; PCBack captures the PC on the same edge.
oIouD  out  1  memory address select: 0=PC, 1=ALUOut.
oLeMem  out  1  memory read enable.
oEscreveMem  out  1  memory write enable.
oEscreveReg  out  1  register file write enable.
oMem2Reg  out  2  writeback select: 0=ALUOut, 1=PC, 2=MDR.
oOrigAULA  out  2  ALU A select: 0=PCBack, 1=A, 2=PC.
oOrigBULA  out  2  ALU B select: 0=B, 1=constant 4, 2=Imm.
oOrigPC  out  1  PC source: 0=ALU result, 1=ALUOut.
oALUControl  out  4  ALU operation code.
oEstado  out  ESTADO_W  current state, for debug display.
oErro  out  1  high while in ERRO.

Behaviour:
- Reset: on any rising edge with iRST=1, state becomes FETCH(0). While iRST=1, all write/read enables are forced to 0, oErro=0 and oEstado=0. Reset mid-instruction abandons the instruction.
- Outputs are Moore, decoded from state. The single exception is oEscrevePC in BRANCH, which also depends on iZero.
- Every output not listed for a state is 0. oALUControl defaults to ADD.
- States and their outputs:
  - FETCH(0): IouD=0, LeMem=1, EscreveIR=1, OrigAULA=2, OrigBULA=1, ADD, OrigPC=0, EscrevePC=1. Next state: DECODE.
  - DECODE(1): OrigAULA=0, OrigBULA=2, ADD, so ALUOut receives PC+imm. The A/B registers load.
    - opcode 0000011 or 0100011 -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> ERRO
  - MEM_ADDR(2): OrigAULA=1, OrigBULA=2, ADD. Next: load -> MEM_READ, store -> MEM_WRITE.
  - MEM_READ(3): IouD=1, LeMem=1. Next: WB_LOAD.
  - WB_LOAD(4): EscreveReg=1, Mem2Reg=2. Next: FETCH.
  - MEM_WRITE(5): IouD=1, EscreveMem=1. Next: FETCH.
  - EXEC_R(6): OrigAULA=1, OrigBULA=0, ALU op from funct3/funct7. Next: WB_R.
  - WB_R(7): EscreveReg=1, Mem2Reg=0. Next: FETCH.
  - BRANCH(8): OrigAULA=1, OrigBULA=0, SUB, OrigPC=1, EscrevePC=iZero. Next: FETCH.
  - JAL(9): OrigPC=1, EscrevePC=1, EscreveReg=1, Mem2Reg=1. rd receives the old PC+4, because PC updates on the same edge. Next: FETCH.
  - EXEC_I(10): OrigAULA=1, OrigBULA=2, ALU op from funct3. Next: WB_R.
  - ERRO(15): oErro=1, all enables 0. Stays until iRST. With ERRO_HALT=0, ERRO is never entered and illegal encodings go DECODE -> FETCH.
- Latency in cycles: lw 5; sw, R-type and I-type 4; beq and jal 3.
- ALU codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7.
- R-type decode:
  - funct3 000: funct7[5]=0 -> ADD, funct7[5]=1 -> SUB
  - funct3 111 -> AND, 110 -> OR, 010 -> SLT
  - any other funct3/funct7 combination is illegal -> ERRO
- I-type decode: funct3 000 -> ADD, 111 -> AND, 110 -> OR, 010 -> SLT; others are illegal.
- Width checks in DECODE: lw and sw require funct3=010; beq requires funct3=000; otherwise illegal.
- Unused state codes (11-14) transition to FETCH.

Decomposition:
- Package controle_pkg holds:
  - state enum (ESTADO_W bits) with the encodings above;
  - ALU operation constants;
  - opcode constants OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_OPIMM, OPC_BRANCH, OPC_JAL;
  - mux-select constants for Mem2Reg, OrigAULA and OrigBULA.
- Sub-module controle_ula: combinational; inputs are the state class, funct3 and funct7[5]; outputs are oALUControl and an illegal flag consumed by the FSM.

Test Plan:
1. Reset mid-operation: assert iRST for 1 cycle while in MEM_READ -> next state FETCH, oEstado=0, all enables 0 while iRST=1, oErro=0.
2. lw x5,8(x1), iInst=0x0080A283 -> oEstado sequence 0,1,2,3,4,0; in state 4 oEscreveReg=1 and oMem2Reg=2; in state 3 oIouD=1 and oLeMem=1.
3. sw x5,8(x1), iInst=0x0050A423 -> sequence 0,1,2,5,0; oEscreveMem=1 only in state 5, with oIouD=1; oEscreveReg never asserted.
4. beq x1,x2,8, iInst=0x00208463 -> in state 8, oALUControl=6 and oOrigPC=1. With iZero=1, oEscrevePC=1; with iZero=0, oEscrevePC=0. Both cases return to FETCH after 3 cycles.
5. sub x3,x1,x2, iInst=0x402081B3 -> EXEC_R with oALUControl=6, then WB_R with oEscreveReg=1 and oMem2Reg=0. Repeat with 0x002081B3 (add) -> oALUControl=2.
6. Illegal opcode, iInst=0x0000007F -> DECODE then ERRO. oErro=1 and oEstado=15 hold for 10 cycles with all enables 0; iRST=1 returns to FETCH. With ERRO_HALT=0 -> FETCH directly after DECODE.
